max3_frame_ctrl: RTL and testbench

Frame-based signed-maximum reducer that sequences the existing combinational max3sint16b datapath.
- Accepts a frame of N beats, each carrying two signed 16-bit samples, over a valid/ready handshake.
- Folds each beat into a running maximum, then presents one result per frame on an output valid/ready handshake.
- Sits between a sample source (ADC capture / FIFO) and a consumer register or bus.

---
 rtl/max3_pkg.sv | 14 +
 rtl/max3_frame_ctrl_if.sv | 31 +++
 rtl/max3sint16b.sv | 18 +
 rtl/max3_frame_ctrl.sv | 102 ++++++++++
 tb/tb_max3_frame_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max3_pkg.sv
// Shared definitions for the max3 frame reducer.
//   SAMPLE_W   : width of one signed sample
//   SINT16_MIN : most negative 16-bit value; running-max seed
//   state_t    : controller FSM encoding (IDLE/RUN/HOLD)
package max3_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic signed [SAMPLE_W-1:0] SINT16_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/max3_frame_ctrl_if.sv
// Stream bundle for max3_frame_ctrl.
//   in_valid/in_ready/in_a/in_b        : beat input channel
//   out_valid/out_ready/out_max/out_beats : frame result channel
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and data stable until that edge; ready never
// depends combinationally on valid.
// master = sample source / result consumer side, slave = the reducer.
interface max3_frame_ctrl_if #(
  parameter int LEN_W = 8
);
  import max3_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic signed [SAMPLE_W-1:0] in_a;
  logic signed [SAMPLE_W-1:0] in_b;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [SAMPLE_W-1:0] out_max;
  logic [LEN_W-1:0]           out_beats;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_max, out_beats
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_max, out_beats
  );
endinterface

// File: rtl/max3sint16b.sv
// Combinational signed maximum of three 16-bit samples.
//   a, b, c : signed inputs
//   y       : signed maximum of a, b, c
module max3sint16b
  import max3_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  input  logic signed [SAMPLE_W-1:0] c,
  output logic signed [SAMPLE_W-1:0] y
);
  logic signed [SAMPLE_W-1:0] ab;

  always_comb begin
    ab = (a > b) ? a : b;
    y  = (ab > c) ? ab : c;
  end
endmodule

// File: rtl/max3_frame_ctrl.sv
// Frame-based signed-maximum reducer.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a frame (only honoured in IDLE with frame_len != 0)
//   frame_len  : beats in the frame, latched on accepted start
//   abort      : drop the running frame (RUN only)
//   busy       : high in RUN or HOLD
//   dbg_state  : current FSM state
//   bus        : beat input and result output channels (slave side)
// Every output is a register or a decode of state; no input reaches an
// output combinationally.
module max3_frame_ctrl
  import max3_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 abort,
  output logic                 busy,
  output state_t               dbg_state,
  max3_frame_ctrl_if.slave     bus
);
  state_t                     state, state_nx;
  logic signed [SAMPLE_W-1:0] acc;
  logic signed [SAMPLE_W-1:0] fold_y;
  logic [LEN_W-1:0]           rem;
  logic [LEN_W-1:0]           len_q;
  logic signed [SAMPLE_W-1:0] out_max_q;
  logic [LEN_W-1:0]           out_beats_q;
  logic                       accept;
  logic                       last_beat;

  max3sint16b u_fold (
    .a (acc),
    .b (bus.in_a),
    .c (bus.in_b),
    .y (fold_y)
  );

  // in_ready is exactly (state == RUN), so acceptance needs only in_valid.
  assign accept    = (state == RUN) && bus.in_valid && !abort;
  assign last_beat = accept && (rem == LEN_W'(1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && (frame_len != '0)) state_nx = RUN;
      RUN: begin
        if (abort)          state_nx = IDLE;
        else if (last_beat) state_nx = HOLD;
      end
      HOLD: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= SINT16_MIN;
      rem         <= '0;
      len_q       <= '0;
      out_max_q   <= '0;
      out_beats_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start && (frame_len != '0)) begin
            rem   <= frame_len;
            len_q <= frame_len;
            acc   <= SINT16_MIN;
          end
        end
        RUN: begin
          if (abort) begin
            acc <= SINT16_MIN;
            rem <= '0;
          end else if (accept) begin
            acc <= fold_y;
            rem <= rem - LEN_W'(1);
            // Final beat: publish the fresh fold, not the stale accumulator.
            if (last_beat) begin
              out_max_q   <= fold_y;
              out_beats_q <= len_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == RUN);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_max   = out_max_q;
  assign bus.out_beats = out_beats_q;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_max3_frame_ctrl.sv
module tb_max3_frame_ctrl;
  import max3_pkg::*;

  localparam int LEN_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             abort;
  logic             busy;
  state_t           dbg_state;

  max3_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

  max3_frame_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .abort     (abort),
    .busy      (busy),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] a_q[$];
  logic signed [15:0] b_q[$];
  logic [15:0]        exp_q[$];
  logic [LEN_W-1:0]   exp_beats_q[$];
  logic [15:0]        last_max;
  logic [LEN_W-1:0]   last_beats;

  // Reference: maximum over every sample of the pending frame.
  function automatic logic [15:0] model_max();
    int m = -32768;
    foreach (a_q[i]) begin
      if (int'(a_q[i]) > m) m = int'(a_q[i]);
      if (int'(b_q[i]) > m) m = int'(b_q[i]);
    end
    return 16'(m);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int len);
    start     = 1'b1;
    frame_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_beats(input int gap_pct, output int ready_cycles);
    int budget = 4000;
    ready_cycles = 0;
    while (a_q.size() > 0 && budget > 0) begin
      budget--;
      if ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_a     = a_q[0];
        bus.in_b     = b_q[0];
      end
      if (bus.in_ready) ready_cycles++;
      if (bus.in_valid && bus.in_ready) begin
        void'(a_q.pop_front());
        void'(b_q.pop_front());
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (a_q.size() != 0) begin
      n_fail++;
      $display("FAIL feed_timeout: %0d beats left unaccepted, required 0", a_q.size());
      a_q.delete();
      b_q.delete();
    end
  endtask

  task automatic collect_result(input int hold);
    int budget = 200;
    logic [15:0]      em;
    logic [LEN_W-1:0] eb;
    em = exp_q.pop_front();
    eb = exp_beats_q.pop_front();
    while (!bus.out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout: out_valid=%b required 1", bus.out_valid);
    end
    n_checks++;
    if (bus.out_max !== em) begin
      n_fail++;
      $display("FAIL out_max: got %0d required %0d", $signed(bus.out_max), $signed(em));
    end
    n_checks++;
    if (bus.out_beats !== eb) begin
      n_fail++;
      $display("FAIL out_beats: got %0d required %0d", bus.out_beats, eb);
    end
    // Hold off the consumer; abort during HOLD must not drop the result.
    for (int i = 0; i < hold; i++) begin
      abort = (i == 1);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_max !== em || bus.out_beats !== eb) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d valid=%b max=%0d beats=%0d required 1/%0d/%0d",
                 i, bus.out_valid, $signed(bus.out_max), bus.out_beats, $signed(em), eb);
      end
    end
    abort = 1'b0;
    // start on the HOLD exit cycle is ignored.
    bus.out_ready = 1'b1;
    start         = 1'b1;
    frame_len     = LEN_W'(3);
    @(negedge clk);
    bus.out_ready = 1'b0;
    start         = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_exit: out_valid=%b busy=%b required 0/0", bus.out_valid, busy);
    end
    last_max   = em;
    last_beats = eb;
  endtask

  task automatic run_frame(input int gap_pct, input int hold, output int rc);
    int len = a_q.size();
    exp_q.push_back(model_max());
    exp_beats_q.push_back(LEN_W'(len));
    start_frame(len);
    feed_beats(gap_pct, rc);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_latency: out_valid=%b required 1 right after final beat", bus.out_valid);
    end
    collect_result(hold);
  endtask

  task automatic push_beat(input int a, input int b);
    a_q.push_back(16'(a));
    b_q.push_back(16'(b));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0 ||
        bus.out_max !== 16'd0 || bus.out_beats !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b ready=%b busy=%b max=%0d beats=%0d required all 0",
               bus.out_valid, bus.in_ready, busy, bus.out_max, bus.out_beats);
    end
    start_frame(0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_start: busy=%b in_ready=%b required 0/0", busy, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int rc;
    push_beat(5, -7);
    push_beat(12, 3);
    push_beat(-1, 11);
    run_frame(0, 0, rc);
    n_checks++;
    if (rc != 3) begin
      n_fail++;
      $display("FAIL basic_ready_cycles: got %0d required 3", rc);
    end
  endtask

  task automatic test_neg_extremes();
    int rc;
    push_beat(-32768, -32768);
    push_beat(-32768, -32768);
    run_frame(0, 0, rc);
    push_beat(-5, -300);
    push_beat(-2, -32768);
    run_frame(0, 1, rc);
  endtask

  task automatic test_backpressure();
    logic [6:0] pat = 7'b1011001;
    push_beat(100, -1);
    push_beat(32767, 0);
    push_beat(7, 8);
    push_beat(9, -9);
    exp_q.push_back(model_max());
    exp_beats_q.push_back(LEN_W'(4));
    start_frame(4);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = pat[i];
      if (pat[i] && a_q.size() > 0) begin
        bus.in_a = a_q[0];
        bus.in_b = b_q[0];
        if (bus.in_ready) begin
          void'(a_q.pop_front());
          void'(b_q.pop_front());
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (a_q.size() != 0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_done: left=%0d out_valid=%b required 0/1", a_q.size(), bus.out_valid);
      a_q.delete();
      b_q.delete();
    end
    collect_result(5);
  endtask

  task automatic test_abort();
    push_beat(3, 4);
    push_beat(50, 60);
    start_frame(4);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = a_q.pop_front();
      bus.in_b     = b_q.pop_front();
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = 16'sd32767;
    bus.in_b     = 16'sd1;
    abort        = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b ready=%b valid=%b required 0/0/0", busy, bus.in_ready, bus.out_valid);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_max !== last_max || bus.out_beats !== last_beats) begin
      n_fail++;
      $display("FAIL abort_no_result: valid=%b max=%0d beats=%0d required 0/%0d/%0d",
               bus.out_valid, $signed(bus.out_max), bus.out_beats, $signed(last_max), last_beats);
    end
    // start during RUN must be ignored.
    push_beat(-9, 17);
    push_beat(2, -4);
    exp_q.push_back(model_max());
    exp_beats_q.push_back(LEN_W'(2));
    start_frame(2);
    bus.in_valid = 1'b1;
    bus.in_a     = a_q.pop_front();
    bus.in_b     = b_q.pop_front();
    start        = 1'b1;
    frame_len    = LEN_W'(5);
    @(negedge clk);
    start    = 1'b0;
    bus.in_a = a_q.pop_front();
    bus.in_b = b_q.pop_front();
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run: out_valid=%b required 1 after 2 beats", bus.out_valid);
    end
    collect_result(1);
  endtask

  task automatic test_reset_hold();
    int rc;
    push_beat(1, 2);
    start_frame(1);
    feed_beats(0, rc);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 16'sd2) begin
      n_fail++;
      $display("FAIL pre_reset_hold: valid=%b max=%0d required 1/2", bus.out_valid, $signed(bus.out_max));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_max !== 16'd0 || bus.out_beats !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: valid=%b max=%0d beats=%0d busy=%b required 0/0/0/0",
               bus.out_valid, $signed(bus.out_max), bus.out_beats, busy);
    end
    last_max   = '0;
    last_beats = '0;
  endtask

  task automatic test_max_frame();
    int rc;
    for (int i = 0; i < 255; i++) push_beat(i - 128, -i);
    run_frame(0, 0, rc);
    n_checks++;
    if (rc != 255) begin
      n_fail++;
      $display("FAIL max_frame_ready_cycles: got %0d required 255", rc);
    end
  endtask

  task automatic test_random();
    int rc;
    int len;
    int v;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++) begin
        v = ($urandom_range(3) == 0) ? ($urandom_range(1) ? 32767 : -32768)
                                     : int'($signed(16'($urandom)));
        a_q.push_back(16'(v));
        b_q.push_back(16'($urandom));
      end
      run_frame(30, $urandom_range(3), rc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    frame_len     = '0;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    last_max      = '0;
    last_beats    = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_neg_extremes();
    test_backpressure();
    test_abort();
    test_reset_hold();
    test_max_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
